multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter XLEN, default 32: data width of every register in bits.
REQ-002 Parameter NREGS, default 32: number of registers; a power of two, at least 2.
REQ-003 Parameter NRP, default 2: number of read ports, from 1 to 4.
REQ-004 Parameter NWP, default 1: number of write ports, 1 or 2.
REQ-005 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-007 Derived constant AW = clog2(NREGS).
REQ-008 clk  in  1  single clock; all state updates on the rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 ra  in  NRP*AW  read addresses; port p occupies bits [p*AW +: AW].
REQ-011 rd  out  NRP*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
REQ-012 we  in  NWP  write enable, one bit per write port.
REQ-013 wa  in  NWP*AW  write addresses, packed per write port.
REQ-014 wd  in  NWP*XLEN  write data, packed per write port.
REQ-015 clr_req  in  1  single-cycle request to sweep-clear all registers.
REQ-016 clr_busy  out  1  high while a sweep clear is in progress.
REQ-017 clr_done  out  1  one-cycle pulse when a sweep clear completes.

Function
REQ-018 Reads are combinational: rd[p] = regs[ra[p]], with zero added cycles of latency.
REQ-019 If ZERO_REG=1, a read of address 0 returns 0 and writes to address 0 are discarded.
REQ-020 Writes take effect at the rising edge: if we[w] is set, regs[wa[w]] <= wd[w].
REQ-021 If two write ports target the same address in one cycle, port NWP-1 wins.
REQ-022 If BYPASS=1 and a write is enabled to a read address (non-zero when ZERO_REG=1), rd returns the winning wd combinationally in that cycle.
REQ-023 If BYPASS=0, rd returns the old value until the write edge.
REQ-024 The clear FSM has three states: IDLE, SWEEP, DONE.
REQ-025 IDLE -> SWEEP when clr_req=1; the index counter loads 0.
REQ-026 In SWEEP, one register per cycle, regs[idx] <= 0, then idx increments.
REQ-027 SWEEP -> DONE at the edge that clears idx = NREGS-1, so the sweep lasts exactly NREGS cycles.
REQ-028 DONE -> IDLE unconditionally after one cycle; clr_done = 1 only in DONE.
REQ-029 clr_busy = 1 in SWEEP and DONE, and 0 in IDLE.
REQ-030 While clr_busy=1, all writes are dropped and clr_req is ignored.
REQ-031 While clr_busy=1, reads stay combinational but bypass is disabled.
REQ-032 A clr_req in the same cycle as a write in IDLE: the write commits, then the sweep starts next cycle and overwrites it.
REQ-033 The index counter wraps modulo NREGS and is never read outside SWEEP.

Reset
REQ-034 While rst_n=0, all registers clear to 0 immediately (asynchronous).
REQ-035 While rst_n=0, the FSM goes to IDLE, idx=0, clr_busy=0, clr_done=0.
REQ-036 Reset asserted mid-sweep aborts the sweep, and clr_done is not pulsed.
REQ-037 Reset deassertion is clean; the first edge after rst_n rises may accept writes.

Structure
REQ-038 A shared package holds the clear-state enum (IDLE/SWEEP/DONE) and the default parameter constants.
REQ-039 The clear FSM plus counter is one sub-module, regfile_clear_ctrl, with outputs busy, done, idx and clr_we.
REQ-040 Storage, write arbitration and the read/bypass muxes live in multiport_regfile.

Verification
REQ-041 Reset, then write x5=0xDEADBEEF, next cycle read ra0=5 -> rd0=0xDEADBEEF.
REQ-042 we=1, wa=7, wd=0x1234 with ra1=7 in the same cycle -> rd1=0x1234 with BYPASS=1, 0 with BYPASS=0.
REQ-043 Write x0=0xFFFFFFFF, read ra0=0 -> rd0=0; with NWP=2, both ports write x3 (A, then B) -> x3=B.
REQ-044 Fill all registers, pulse clr_req -> clr_busy high for 33 cycles, clr_done at cycle 33, all reads 0 after; a write issued mid-sweep is dropped.
REQ-045 Assert rst_n=0 at sweep cycle 10 -> clr_busy=0 immediately, all registers 0, no clr_done pulse.

Source files
------------

// File: rtl/multiport_regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
// Holds the sweep-clear FSM state encoding used by the clear controller.
package multiport_regfile_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NREGS_DEF    = 32;
    localparam int unsigned NRP_DEF      = 2;
    localparam int unsigned NWP_DEF      = 1;
    localparam int unsigned BYPASS_DEF   = 1;
    localparam int unsigned ZERO_REG_DEF = 1;

    typedef enum logic [1:0] {
        ClrIdle  = 2'd0,
        ClrSweep = 2'd1,
        ClrDone  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sweep-clear sequencer: walks every register index once, then pulses done.
// Busy covers both the sweep and the done cycle so the datapath can block writes.
module regfile_clear_ctrl
    import multiport_regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] idx,
    output logic          clr_we
);

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ClrIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy    = 1'b0;
        done    = 1'b0;
        clr_we  = 1'b0;
        unique case (state_q)
            ClrIdle: begin
                if (clr_req) begin
                    state_d = ClrSweep;
                    idx_d   = '0;
                end
            end
            ClrSweep: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // Counter wraps naturally back to 0 after the last register.
                idx_d  = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = ClrDone;
                end
            end
            ClrDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ClrIdle;
            end
            default: begin
                state_d = ClrIdle;
            end
        endcase
    end

    assign idx = idx_q;

endmodule

// File: rtl/multiport_regfile.sv
// Parameterised multi-read/multi-write register file with optional write
// forwarding, hardwired zero register and a one-register-per-cycle sweep clear.
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRP      = NRP_DEF,
    parameter int unsigned NWP      = NWP_DEF,
    parameter int unsigned BYPASS   = BYPASS_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   ra,
    output logic [NRP*XLEN-1:0] rd,
    input  logic [NWP-1:0]      we,
    input  logic [NWP*AW-1:0]   wa,
    input  logic [NWP*XLEN-1:0] wd,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    logic [XLEN-1:0] regs_q [NREGS];

    logic [AW-1:0]   ra_arr [NRP];
    logic [AW-1:0]   wa_arr [NWP];
    logic [XLEN-1:0] wd_arr [NWP];
    logic [NWP-1:0]  wr_ok;

    logic [AW-1:0]   clr_idx;
    logic            clr_we;
    logic            busy;

    regfile_clear_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .done    (clr_done),
        .idx     (clr_idx),
        .clr_we  (clr_we)
    );

    assign clr_busy = busy;

    always_comb begin
        for (int unsigned p = 0; p < NRP; p++) begin
            ra_arr[p] = ra[p*AW +: AW];
        end
        for (int unsigned w = 0; w < NWP; w++) begin
            wa_arr[w] = wa[w*AW +: AW];
            wd_arr[w] = wd[w*XLEN +: XLEN];
            // Register 0 absorbs nothing when it is hardwired.
            wr_ok[w]  = we[w] && !busy && !((ZERO_REG != 0) && (wa_arr[w] == '0));
        end
    end

    // Later write ports overwrite earlier ones, so port NWP-1 wins on conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_we) begin
            regs_q[clr_idx] <= '0;
        end else begin
            for (int unsigned w = 0; w < NWP; w++) begin
                if (wr_ok[w]) begin
                    regs_q[wa_arr[w]] <= wd_arr[w];
                end
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            logic [XLEN-1:0] val;
            val = regs_q[ra_arr[p]];
            if (BYPASS != 0) begin
                for (int unsigned w = 0; w < NWP; w++) begin
                    if (wr_ok[w] && (wa_arr[w] == ra_arr[p])) begin
                        val = wd_arr[w];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra_arr[p] == '0)) begin
                val = '0;
            end
            rd[p*XLEN +: XLEN] = val;
        end
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: a two-write-port bypassing instance and a
// single-write-port non-bypassing instance sharing stimulus, scoreboard-checked.
module tb_multiport_regfile;

    localparam int SEL_RD0     = 0;
    localparam int SEL_RD1     = 1;
    localparam int SEL_NB_RD0  = 2;
    localparam int SEL_NB_RD1  = 3;
    localparam int SEL_BUSY    = 4;
    localparam int SEL_DONE    = 5;
    localparam int SEL_NB_BUSY = 6;
    localparam int SEL_NB_DONE = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [63:0] rd_nb;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        clr_req;
    logic        clr_busy, clr_done;
    logic        nb_busy, nb_done;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    multiport_regfile #(
        .XLEN(32), .NREGS(32), .NRP(2), .NWP(2), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rd       (rd),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    multiport_regfile #(
        .XLEN(32), .NREGS(32), .NRP(2), .NWP(1), .BYPASS(0), .ZERO_REG(1)
    ) dut_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rd       (rd_nb),
        .we       (we[0]),
        .wa       (wa[4:0]),
        .wd       (wd[31:0]),
        .clr_req  (clr_req),
        .clr_busy (nb_busy),
        .clr_done (nb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD0:     return rd[31:0];
            SEL_RD1:     return rd[63:32];
            SEL_NB_RD0:  return rd_nb[31:0];
            SEL_NB_RD1:  return rd_nb[63:32];
            SEL_BUSY:    return {31'd0, clr_busy};
            SEL_DONE:    return {31'd0, clr_done};
            SEL_NB_BUSY: return {31'd0, nb_busy};
            default:     return {31'd0, nb_done};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_q();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        check_q();
    endtask

    task automatic set_wr(input int port, input logic [4:0] a, input logic [31:0] d);
        we[port]          = 1'b1;
        wa[port*5 +: 5]   = a;
        wd[port*32 +: 32] = d;
    endtask

    task automatic set_ra(input int port, input logic [4:0] a);
        ra[port*5 +: 5] = a;
    endtask

    initial begin
        rst_n   = 1'b1;
        ra      = '0;
        we      = '0;
        wa      = '0;
        wd      = '0;
        clr_req = 1'b0;
        #1 rst_n = 1'b0;
        set_ra(0, 5);
        set_ra(1, 31);
        #1;
        expect_val("reset_busy", SEL_BUSY, 0);
        expect_val("reset_done", SEL_DONE, 0);
        expect_val("reset_rd0", SEL_RD0, 0);
        expect_val("reset_rd1", SEL_RD1, 0);
        check_q();
        #10 rst_n = 1'b1;
        tick();

        // Basic write then read.
        set_wr(0, 5, 32'hDEAD_BEEF);
        set_ra(0, 0);
        tick();
        we = '0;
        set_ra(0, 5);
        expect_val("wr_rd_x5", SEL_RD0, 32'hDEAD_BEEF);
        expect_val("wr_rd_x5_nb", SEL_NB_RD0, 32'hDEAD_BEEF);
        settle();

        // Same-cycle forwarding vs. none.
        tick();
        set_wr(0, 7, 32'h0000_1234);
        set_ra(1, 7);
        expect_val("bypass_rd1", SEL_RD1, 32'h0000_1234);
        expect_val("nobypass_rd1", SEL_NB_RD1, 32'h0);
        settle();
        tick();
        we = '0;
        expect_val("after_wr_rd1", SEL_RD1, 32'h0000_1234);
        expect_val("after_wr_rd1_nb", SEL_NB_RD1, 32'h0000_1234);
        settle();

        // Writes to x0 are discarded, including the forward path.
        tick();
        set_wr(0, 0, 32'hFFFF_FFFF);
        set_ra(0, 0);
        expect_val("x0_bypass", SEL_RD0, 32'h0);
        settle();
        tick();
        we = '0;
        expect_val("x0_read", SEL_RD0, 32'h0);
        expect_val("x0_read_nb", SEL_NB_RD0, 32'h0);
        settle();

        // Dual write to x3: port 1 wins, both forwarded and committed.
        tick();
        set_wr(0, 3, 32'hAAAA_0001);
        set_wr(1, 3, 32'hBBBB_0002);
        set_ra(0, 3);
        expect_val("dual_bypass_x3", SEL_RD0, 32'hBBBB_0002);
        settle();
        tick();
        we = '0;
        expect_val("dual_commit_x3", SEL_RD0, 32'hBBBB_0002);
        settle();
        tick();
        set_wr(1, 9, 32'h0000_0099);
        tick();
        we = '0;
        set_ra(1, 9);
        expect_val("port1_x9", SEL_RD1, 32'h0000_0099);
        settle();

        // Fill everything, then sweep.
        tick();
        for (int i = 1; i < 32; i++) begin
            set_wr(0, 5'(i), 32'h1000_0000 | 32'(i));
            tick();
        end
        we = '0;
        set_ra(0, 31);
        set_ra(1, 1);
        expect_val("fill_x31", SEL_RD0, 32'h1000_001F);
        expect_val("fill_x1", SEL_RD1, 32'h1000_0001);
        settle();

        // clr_req alongside a write: the write lands before the sweep reaches it.
        tick();
        clr_req = 1'b1;
        set_wr(0, 4, 32'h0000_4444);
        set_ra(0, 4);
        set_ra(1, 2);
        expect_val("clrreq_bypass_x4", SEL_RD0, 32'h0000_4444);
        expect_val("clrreq_busy", SEL_BUSY, 0);
        settle();
        tick();
        for (int c = 1; c <= 34; c++) begin
            we      = '0;
            clr_req = 1'b0;
            if (c == 1) expect_val("sweep_x4_kept", SEL_RD0, 32'h0000_4444);
            if (c == 6) expect_val("sweep_x4_cleared", SEL_RD0, 32'h0);
            if (c == 5) begin
                set_wr(0, 2, 32'h0000_0BAD);
                clr_req = 1'b1;
                expect_val("sweep_no_bypass_x2", SEL_RD1, 32'h0);
            end
            expect_val("sweep_busy", SEL_BUSY, (c <= 33) ? 32'd1 : 32'd0);
            expect_val("sweep_done", SEL_DONE, (c == 33) ? 32'd1 : 32'd0);
            expect_val("sweep_busy_nb", SEL_NB_BUSY, (c <= 33) ? 32'd1 : 32'd0);
            expect_val("sweep_done_nb", SEL_NB_DONE, (c == 33) ? 32'd1 : 32'd0);
            settle();
            tick();
        end
        we = '0;
        for (int i = 0; i < 32; i++) begin
            set_ra(0, 5'(i));
            set_ra(1, 5'(31 - i));
            expect_val("post_sweep_rd0", SEL_RD0, 32'h0);
            expect_val("post_sweep_rd1", SEL_RD1, 32'h0);
            settle();
        end

        // Reset in the middle of a sweep.
        tick();
        set_wr(0, 20, 32'h0000_2020);
        tick();
        we = '0;
        set_ra(0, 20);
        expect_val("pre_abort_x20", SEL_RD0, 32'h0000_2020);
        settle();
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            expect_val("abort_busy", SEL_BUSY, 1);
            if (c == 10) expect_val("abort_x20_live", SEL_RD0, 32'h0000_2020);
            settle();
            if (c < 10) tick();
        end
        #1 rst_n = 1'b0;
        #1;
        expect_val("abort_busy_low", SEL_BUSY, 0);
        expect_val("abort_done_low", SEL_DONE, 0);
        expect_val("abort_x20_zero", SEL_RD0, 32'h0);
        check_q();
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_val("abort_no_done", SEL_DONE, 0);
            settle();
        end
        #1 rst_n = 1'b1;
        set_wr(0, 6, 32'h0000_0066);
        tick();
        we = '0;
        set_ra(0, 6);
        expect_val("post_reset_wr_x6", SEL_RD0, 32'h0000_0066);
        expect_val("post_reset_busy", SEL_BUSY, 0);
        expect_val("post_reset_done", SEL_DONE, 0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
